// File: rtl/clock_pkg.sv
// Shared definitions for the clock mode/time-set controller.
// Holds the mode encoding, the field limits, the 7-bit time field type
// and the wrap/clamp step used when a field is edited.
package clock_pkg;

    // One 7-bit time field (hours, minutes or seconds).
    typedef logic [6:0] time_t;

    // Controller mode; the encoding is visible on the mode output.
    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2,
        MODE_SET_SEC = 2'd3
    } mode_e;

    // Highest legal value for each field.
    localparam time_t HR_MAX  = 7'd23;
    localparam time_t MIN_MAX = 7'd59;
    localparam time_t SEC_MAX = 7'd59;

    // One edit step on a field. An out-of-range value (possible when a
    // garbage count was captured from the counter chain) is forced to 0
    // regardless of direction; otherwise the field wraps at 0 and max_val.
    function automatic time_t field_step(input time_t val,
                                         input time_t max_val,
                                         input logic  up);
        time_t res;
        if (val > max_val) begin
            res = '0;
        end else if (up) begin
            res = (val == max_val) ? '0 : val + 7'd1;
        end else begin
            res = (val == '0) ? max_val : val - 7'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Front-panel / counter-chain bundle of the clock set controller.
// The slave side is the controller; the master side is whatever drives
// the buttons and owns the counters.
interface clock_set_ctrl_if;
    import clock_pkg::*;

    // Front-panel buttons (levels, synchronous to clk).
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_dec;

    // Live counts from the counter chain.
    time_t      cur_hr;
    time_t      cur_min;
    time_t      cur_sec;

    // Controls and values back to the counter chain / display.
    logic       run_en;
    logic       sec_tick;
    logic       load;
    time_t      set_hr;
    time_t      set_min;
    time_t      set_sec;
    logic [1:0] mode;
    logic       blink;

    modport master (
        output btn_mode, btn_inc, btn_dec,
        output cur_hr, cur_min, cur_sec,
        input  run_en, sec_tick, load,
        input  set_hr, set_min, set_sec,
        input  mode, blink
    );

    modport slave (
        input  btn_mode, btn_inc, btn_dec,
        input  cur_hr, cur_min, cur_sec,
        output run_en, sec_tick, load,
        output set_hr, set_min, set_sec,
        output mode, blink
    );

endinterface

// File: rtl/btn_debounce.sv
// Button debouncer with rising-edge detect.
// Only compiled when CLOCK_SET_CTRL_DEBOUNCE_EN is defined; without the
// macro the controller uses a plain two-register edge detector instead.
// The raw level is registered once, then the filtered level follows it
// only after DEB_CYC consecutive samples that disagree with the current
// filtered level. rise_o is high for one cycle after the filtered level
// goes 0 -> 1.
`ifdef CLOCK_SET_CTRL_DEBOUNCE_EN
module btn_debounce #(
    parameter int DEB_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic             sync_q;
    logic             filt_q;
    logic             filt_d;
    logic             filt_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive disagreeing samples; flip the filtered level on the last one.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q != filt_q) begin
            if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
                filt_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Input register, filtered level, its delayed copy and the stability counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q      <= 1'b0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync_q      <= btn_i;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            cnt_q       <= cnt_d;
        end
    end

    assign level_o = filt_q;
    assign rise_o  = filt_q & ~filt_prev_q;

endmodule
`endif

// File: rtl/clock_set_ctrl.sv
// Mode / time-set controller for the digital clock counter chain.
// - RUN: free-running prescaler produces a one-cycle sec_tick every CLK_HZ cycles.
// - btn_mode steps RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN; entering
//   SET_HR captures the live time, leaving SET_SEC pulses load once.
// - btn_inc / btn_dec edit the selected field with wrap (hours 0..23,
//   minutes/seconds 0..59); out-of-range captures are clamped to 0.
// - blink toggles every CLK_HZ/2 cycles while a field is being edited.
// Optional build macro: CLOCK_SET_CTRL_DEBOUNCE_EN inserts a btn_debounce
// stage (window DEB_CYC) in front of each button's edge detector.
// All outputs come straight from registers.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int DEB_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    clock_set_ctrl_if.slave  bus
);

    localparam int PRE_W    = $clog2(CLK_HZ);
    localparam int HALF_CYC = CLK_HZ / 2;
    localparam int HALF_W   = $clog2(HALF_CYC);

    // Button index map inside the packed vectors below.
    localparam int BTN_MODE = 0;
    localparam int BTN_INC  = 1;
    localparam int BTN_DEC  = 2;

    logic [2:0] btn_raw;
    logic [2:0] btn_rise;

    assign btn_raw = {bus.btn_dec, bus.btn_inc, bus.btn_mode};

`ifdef CLOCK_SET_CTRL_DEBOUNCE_EN
    // Filtered levels are not needed here; only the edges drive the FSM.
    logic [2:0] btn_level_unused;
`else
    // The stability window only applies when the debouncer is built in.
    localparam int unused_deb_cyc = DEB_CYC;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
`ifdef CLOCK_SET_CTRL_DEBOUNCE_EN
            btn_debounce #(
                .DEB_CYC (DEB_CYC)
            ) u_debounce (
                .clk     (clk),
                .rst     (rst),
                .btn_i   (btn_raw[gi]),
                .level_o (btn_level_unused[gi]),
                .rise_o  (btn_rise[gi])
            );
`else
            logic cur_q;
            logic prev_q;

            // Register the raw level and keep the previous sample for edge detect.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cur_q  <= 1'b0;
                    prev_q <= 1'b0;
                end else begin
                    cur_q  <= btn_raw[gi];
                    prev_q <= cur_q;
                end
            end

            assign btn_rise[gi] = cur_q & ~prev_q;
`endif
        end
    endgenerate

    logic mode_ev;
    logic inc_ev;
    logic dec_ev;
    logic step_ev;

    assign mode_ev = btn_rise[BTN_MODE];
    assign inc_ev  = btn_rise[BTN_INC];
    assign dec_ev  = btn_rise[BTN_DEC];
    // A mode edge swallows any inc/dec in the same cycle; inc+dec together cancel.
    assign step_ev = (inc_ev ^ dec_ev) & ~mode_ev;

    mode_e              state_q;
    mode_e              state_d;
    time_t              set_hr_q;
    time_t              set_hr_d;
    time_t              set_min_q;
    time_t              set_min_d;
    time_t              set_sec_q;
    time_t              set_sec_d;
    logic [PRE_W-1:0]   presc_q;
    logic [PRE_W-1:0]   presc_d;
    logic [HALF_W-1:0]  half_q;
    logic [HALF_W-1:0]  half_d;
    logic               run_en_q;
    logic               run_en_d;
    logic               sec_tick_q;
    logic               sec_tick_d;
    logic               load_q;
    logic               load_d;
    logic               blink_q;
    logic               blink_d;

    // Next mode: every mode edge advances one step around the ring.
    always_comb begin
        state_d = state_q;
        if (mode_ev) begin
            case (state_q)
                MODE_RUN:     state_d = MODE_SET_HR;
                MODE_SET_HR:  state_d = MODE_SET_MIN;
                MODE_SET_MIN: state_d = MODE_SET_SEC;
                MODE_SET_SEC: state_d = MODE_RUN;
                default:      state_d = MODE_RUN;
            endcase
        end
    end

    // Datapath: capture, field edits, prescaler, load strobe and blink.
    always_comb begin
        set_hr_d   = set_hr_q;
        set_min_d  = set_min_q;
        set_sec_d  = set_sec_q;
        presc_d    = '0;
        sec_tick_d = 1'b0;
        load_d     = 1'b0;
        half_d     = '0;
        blink_d    = 1'b0;
        run_en_d   = (state_d == MODE_RUN);

        case (state_q)
            MODE_RUN: begin
                if (mode_ev) begin
                    // Start editing from whatever the counters show right now.
                    set_hr_d  = bus.cur_hr;
                    set_min_d = bus.cur_min;
                    set_sec_d = bus.cur_sec;
                end else if (presc_q == PRE_W'(CLK_HZ - 1)) begin
                    sec_tick_d = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            MODE_SET_HR: begin
                if (step_ev) begin
                    set_hr_d = field_step(set_hr_q, HR_MAX, inc_ev);
                end
            end
            MODE_SET_MIN: begin
                if (step_ev) begin
                    set_min_d = field_step(set_min_q, MIN_MAX, inc_ev);
                end
            end
            MODE_SET_SEC: begin
                if (step_ev) begin
                    set_sec_d = field_step(set_sec_q, SEC_MAX, inc_ev);
                end
                // Leaving the set sequence: counters pick up set_* in the first RUN cycle.
                if (mode_ev) begin
                    load_d = 1'b1;
                end
            end
            default: begin
                presc_d = '0;
            end
        endcase

        // Blink restarts lit on every field change and runs only while editing.
        if (state_d != MODE_RUN) begin
            if (state_d != state_q) begin
                blink_d = 1'b1;
                half_d  = '0;
            end else if (half_q == HALF_W'(HALF_CYC - 1)) begin
                blink_d = ~blink_q;
                half_d  = '0;
            end else begin
                blink_d = blink_q;
                half_d  = half_q + 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= MODE_RUN;
            set_hr_q   <= '0;
            set_min_q  <= '0;
            set_sec_q  <= '0;
            presc_q    <= '0;
            half_q     <= '0;
            run_en_q   <= 1'b1;
            sec_tick_q <= 1'b0;
            load_q     <= 1'b0;
            blink_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            set_hr_q   <= set_hr_d;
            set_min_q  <= set_min_d;
            set_sec_q  <= set_sec_d;
            presc_q    <= presc_d;
            half_q     <= half_d;
            run_en_q   <= run_en_d;
            sec_tick_q <= sec_tick_d;
            load_q     <= load_d;
            blink_q    <= blink_d;
        end
    end

    assign bus.mode     = state_q;
    assign bus.run_en   = run_en_q;
    assign bus.sec_tick = sec_tick_q;
    assign bus.load     = load_q;
    assign bus.set_hr   = set_hr_q;
    assign bus.set_min  = set_min_q;
    assign bus.set_sec  = set_sec_q;
    assign bus.blink    = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Testbench for clock_set_ctrl (CLK_HZ=10, DEB_CYC=4).
// A behavioural model tracks mode, fields, the second count and the blink
// phase from the button history; a compare process checks every output on
// every falling edge. Directed sections pin the model with literal values,
// then a randomized phase exercises buttons, captures and resets.
module tb_clock_set_ctrl;

    localparam int CLK_HZ  = 10;
    localparam int DEB_CYC = 4;
    localparam int HALF    = CLK_HZ / 2;

`ifdef CLOCK_SET_CTRL_DEBOUNCE_EN
    localparam int PRESS_HOLD  = 6;
    localparam int PRESS_GAP   = 10;
    localparam int GLITCH_EXP  = 3;
    localparam int EXP_LAT     = 6;
    localparam int TOGGLE_ODDS = 12;
`else
    localparam int PRESS_HOLD  = 2;
    localparam int PRESS_GAP   = 3;
    localparam int GLITCH_EXP  = 4;
    localparam int EXP_LAT     = 2;
    localparam int TOGGLE_ODDS = 4;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    clock_set_ctrl_if bus_if ();

    clock_set_ctrl #(
        .CLK_HZ  (CLK_HZ),
        .DEB_CYC (DEB_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- behavioural model ----------------
    int m_mode, m_hr, m_min, m_sec, m_run_cnt, m_set_cyc;
    bit m_tick, m_load;
    bit fl1 [3];
    bit fl2 [3];
    bit m_ev [3];
    bit m_raw [3];
    bit rawh [3][DEB_CYC];

    task automatic model_reset();
        m_mode = 0; m_hr = 0; m_min = 0; m_sec = 0;
        m_run_cnt = 0; m_set_cyc = 0; m_tick = 0; m_load = 0;
        for (int b = 0; b < 3; b++) begin
            fl1[b] = 0; fl2[b] = 0;
            for (int k = 0; k < DEB_CYC; k++) rawh[b][k] = 0;
        end
    endtask

    function automatic int edit(input int v, input int maxv, input bit up);
        if (v > maxv) return 0;
        return up ? (v + 1) % (maxv + 1) : (v + maxv) % (maxv + 1);
    endfunction

    initial begin : model
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst) begin
                model_reset();
            end else begin
                m_raw[0] = bus_if.btn_mode;
                m_raw[1] = bus_if.btn_inc;
                m_raw[2] = bus_if.btn_dec;
                for (int b = 0; b < 3; b++) m_ev[b] = fl1[b] & ~fl2[b];
                m_tick = 0;
                m_load = 0;
                if (m_ev[0]) begin
                    if (m_mode == 0) begin
                        m_hr  = int'(bus_if.cur_hr);
                        m_min = int'(bus_if.cur_min);
                        m_sec = int'(bus_if.cur_sec);
                        m_mode = 1;
                        m_set_cyc = 0;
                    end else if (m_mode == 3) begin
                        m_mode = 0;
                        m_load = 1;
                        m_run_cnt = 0;
                    end else begin
                        m_mode = m_mode + 1;
                        m_set_cyc = 0;
                    end
                end else if (m_mode == 0) begin
                    m_run_cnt = (m_run_cnt + 1) % CLK_HZ;
                    m_tick = (m_run_cnt == 0);
                end else begin
                    m_set_cyc++;
                    if (m_ev[1] != m_ev[2]) begin
                        if (m_mode == 1)      m_hr  = edit(m_hr, 23, m_ev[1]);
                        else if (m_mode == 2) m_min = edit(m_min, 59, m_ev[1]);
                        else                  m_sec = edit(m_sec, 59, m_ev[1]);
                    end
                end
                // Filtered level history for the next edges.
                for (int b = 0; b < 3; b++) begin
                    bit nf;
`ifdef CLOCK_SET_CTRL_DEBOUNCE_EN
                    bit all_diff;
                    all_diff = 1;
                    for (int k = 0; k < DEB_CYC; k++)
                        if (rawh[b][k] == fl1[b]) all_diff = 0;
                    nf = all_diff ? ~fl1[b] : fl1[b];
                    for (int k = DEB_CYC - 1; k > 0; k--) rawh[b][k] = rawh[b][k-1];
                    rawh[b][0] = m_raw[b];
`else
                    nf = m_raw[b];
`endif
                    fl2[b] = fl1[b];
                    fl1[b] = nf;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        forever begin
            int e_mode, e_hr, e_min, e_sec;
            bit e_run, e_tick, e_load, e_blink;
            bit ok;
            @(negedge clk);
            if (!rst) begin
                e_mode = 0; e_hr = 0; e_min = 0; e_sec = 0;
                e_run = 1; e_tick = 0; e_load = 0; e_blink = 0;
            end else begin
                e_mode = m_mode; e_hr = m_hr; e_min = m_min; e_sec = m_sec;
                e_run = (m_mode == 0); e_tick = m_tick; e_load = m_load;
                e_blink = (m_mode != 0) && (((m_set_cyc / HALF) % 2) == 0);
            end
            ok = (int'(bus_if.mode) == e_mode) && (int'(bus_if.set_hr) == e_hr) &&
                 (int'(bus_if.set_min) == e_min) && (int'(bus_if.set_sec) == e_sec) &&
                 (bus_if.run_en == e_run) && (bus_if.sec_tick == e_tick) &&
                 (bus_if.load == e_load) && (bus_if.blink == e_blink);
            n_checks++;
            if (ok) n_pass++;
            else $display("FAIL cycle_cmp t=%0t got mode=%0d set=%0d:%0d:%0d run_en=%0b tick=%0b load=%0b blink=%0b expected mode=%0d set=%0d:%0d:%0d run_en=%0b tick=%0b load=%0b blink=%0b",
                          $time, bus_if.mode, bus_if.set_hr, bus_if.set_min, bus_if.set_sec,
                          bus_if.run_en, bus_if.sec_tick, bus_if.load, bus_if.blink,
                          e_mode, e_hr, e_min, e_sec, e_run, e_tick, e_load, e_blink);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Advance n cycles; returns 2 time units after a rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       bus_if.btn_mode = v;
            1:       bus_if.btn_inc  = v;
            default: bus_if.btn_dec  = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        step(PRESS_HOLD);
        set_btn(b, 1'b0);
        step(PRESS_GAP);
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        bus_if.cur_hr  = 7'(h);
        bus_if.cur_min = 7'(m);
        bus_if.cur_sec = 7'(s);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int ticks, last_tick, first_tick, load_cnt, load_at, tick_at, found;
        bus_if.btn_mode = 0; bus_if.btn_inc = 0; bus_if.btn_dec = 0;
        set_cur(0, 0, 0);
        rst = 0;
        step(3);
        check("reset_mode", int'(bus_if.mode), 0);
        check("reset_run_en", int'(bus_if.run_en), 1);
        check("reset_blink", int'(bus_if.blink), 0);
        check("reset_set_hr", int'(bus_if.set_hr), 0);
        rst = 1;

        // Free run: ticks at cycles 10, 20, 30.
        ticks = 0; last_tick = -1; first_tick = -1;
        for (int i = 1; i <= 35; i++) begin
            step(1);
            if (bus_if.sec_tick) begin
                if (last_tick >= 0) check("tick_gap", i - last_tick, CLK_HZ);
                else first_tick = i;
                last_tick = i;
                ticks++;
            end
        end
        check("tick_count", ticks, 3);
        check("first_tick", first_tick, CLK_HZ);
        $display("free run: %0d ticks", ticks);

        // Full set sequence 12:34:56 -> 14:33:00.
        set_cur(12, 34, 56);
        press(0);
        check("enter_mode", int'(bus_if.mode), 1);
        check("cap_hr", int'(bus_if.set_hr), 12);
        check("cap_min", int'(bus_if.set_min), 34);
        check("cap_sec", int'(bus_if.set_sec), 56);
        check("set_run_en", int'(bus_if.run_en), 0);
        press(1); press(1);
        check("hr_inc2", int'(bus_if.set_hr), 14);
        press(0); press(2);
        check("min_mode", int'(bus_if.mode), 2);
        check("min_dec", int'(bus_if.set_min), 33);
        press(0);
        repeat (4) press(1);
        check("sec_wrap", int'(bus_if.set_sec), 0);
        bus_if.btn_mode = 1;
        load_cnt = 0; load_at = -1; tick_at = -1;
        for (int i = 1; i <= 30; i++) begin
            step(1);
            if (i == PRESS_HOLD) bus_if.btn_mode = 0;
            if (bus_if.load) begin
                load_cnt++;
                load_at = i;
                check("load_hr", int'(bus_if.set_hr), 14);
                check("load_min", int'(bus_if.set_min), 33);
                check("load_sec", int'(bus_if.set_sec), 0);
            end
            if (bus_if.sec_tick && tick_at < 0 && load_at >= 0) tick_at = i;
        end
        check("load_pulses", load_cnt, 1);
        check("tick_after_load", tick_at - load_at, CLK_HZ);
        $display("set sequence: load at %0d, first tick at %0d", load_at, tick_at);

        // Wrap limits.
        set_cur(23, 0, 0);
        press(0);
        press(1); check("hr_23_inc", int'(bus_if.set_hr), 0);
        press(2); check("hr_0_dec", int'(bus_if.set_hr), 23);
        press(0);
        press(2); check("min_0_dec", int'(bus_if.set_min), 59);
        press(0); press(0);
        check("back_run", int'(bus_if.mode), 0);
        set_cur(40, 70, 0);
        press(0);
        check("cap_40", int'(bus_if.set_hr), 40);
        press(1); check("hr_clamp", int'(bus_if.set_hr), 0);
        press(0);
        press(1); check("min_clamp", int'(bus_if.set_min), 0);
        press(0); press(0);
        $display("wrap limits done");

        // Simultaneous events.
        set_cur(5, 6, 7);
        press(0);
        bus_if.btn_inc = 1; bus_if.btn_dec = 1;
        step(PRESS_HOLD);
        bus_if.btn_inc = 0; bus_if.btn_dec = 0;
        step(PRESS_GAP);
        check("incdec_nochange", int'(bus_if.set_hr), 5);
        bus_if.btn_mode = 1; bus_if.btn_inc = 1;
        step(PRESS_HOLD);
        bus_if.btn_mode = 0; bus_if.btn_inc = 0;
        step(PRESS_GAP);
        check("mode_inc_mode", int'(bus_if.mode), 2);
        check("mode_inc_hr", int'(bus_if.set_hr), 5);
        check("mode_inc_min", int'(bus_if.set_min), 6);
        $display("simultaneous events done");

        // Reset mid-set.
        rst = 0;
        #1;
        check("midrst_mode", int'(bus_if.mode), 0);
        check("midrst_blink", int'(bus_if.blink), 0);
        check("midrst_min", int'(bus_if.set_min), 0);
        step(2);
        rst = 1;
        load_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            if (bus_if.load) load_cnt++;
        end
        check("midrst_noload", load_cnt, 0);
        $display("reset mid-set: %0d loads after release", load_cnt);

        // Short glitch and press latency.
        set_cur(3, 0, 0);
        press(0);
        bus_if.btn_inc = 1;
        step(3);
        bus_if.btn_inc = 0;
        step(PRESS_GAP);
        check("glitch", int'(bus_if.set_hr), GLITCH_EXP);
        bus_if.btn_inc = 1;
        found = -1;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (i == PRESS_HOLD) bus_if.btn_inc = 0;
            if (found < 0 && int'(bus_if.set_hr) == GLITCH_EXP + 1) found = i;
        end
        check("press_latency", found, EXP_LAT);
        press(0); press(0); press(0);
        $display("glitch/latency: latency %0d", found);

        // Randomized phase.
        for (int c = 0; c < 2500; c++) begin
            step(1);
            rst = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 4) == 0)
                    set_cur($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127));
                else
                    set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            end
            if ($urandom_range(0, TOGGLE_ODDS) == 0) bus_if.btn_mode = ~bus_if.btn_mode;
            if ($urandom_range(0, TOGGLE_ODDS) == 0) bus_if.btn_inc  = ~bus_if.btn_inc;
            if ($urandom_range(0, TOGGLE_ODDS) == 0) bus_if.btn_dec  = ~bus_if.btn_dec;
        end
        rst = 1;
        step(2);
        $display("random phase done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
